// File: rtl/enigma_key_sequencer.sv
// Per-keypress controller for the Enigma I core: steps the rotors, runs the
// substitution datapath, and hands the ciphertext letter downstream.
module enigma_key_sequencer #(
  parameter int GROUP_LEN = 5,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load_req,
  input  logic             key_valid,
  input  logic [4:0]       key_data,
  output logic             key_ready,
  output logic             step_pulse,
  output logic             load_pulse,
  output logic             cipher_start,
  output logic [4:0]       cipher_in,
  input  logic             cipher_done,
  input  logic [4:0]       cipher_out,
  output logic             out_valid,
  output logic [4:0]       out_data,
  output logic             out_group_end,
  input  logic             out_ready,
  output logic [CNT_W-1:0] char_count,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_bad_key
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP, S_START, S_WAIT, S_OUT
  } state_t;

  localparam logic [4:0] GRP_LAST = 5'(GROUP_LEN - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [4:0] grp_cnt;
  logic [7:0] to_cnt;
  logic       key_bad;

  assign key_bad = (key_data > 5'd25);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Every pulse is a Moore output of its own state, so each lasts exactly one cycle.
  always_comb begin
    state_nxt     = state;
    key_ready     = 1'b0;
    step_pulse    = 1'b0;
    load_pulse    = 1'b0;
    cipher_start  = 1'b0;
    out_valid     = 1'b0;
    out_group_end = 1'b0;
    case (state)
      S_IDLE: begin
        key_ready = !cfg_load_req;
        if (cfg_load_req)             state_nxt = S_LOAD;
        else if (key_valid && !key_bad) state_nxt = S_STEP;
      end
      S_LOAD: begin
        load_pulse = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_STEP: begin
        step_pulse = 1'b1;
        state_nxt  = S_START;
      end
      S_START: begin
        cipher_start = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (cipher_done)            state_nxt = S_OUT;
        else if (to_cnt == TO_LAST) state_nxt = S_IDLE;
      end
      S_OUT: begin
        out_valid     = 1'b1;
        out_group_end = (grp_cnt == GRP_LAST);
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cipher_in   <= 5'd0;
      out_data    <= 5'd0;
      grp_cnt     <= 5'd0;
      to_cnt      <= 8'd0;
      char_count  <= '0;
      err_timeout <= 1'b0;
      err_bad_key <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_valid && key_ready) begin
            if (key_bad) err_bad_key <= 1'b1;
            else         cipher_in   <= key_data;
          end
        end
        S_LOAD: begin
          char_count  <= '0;
          grp_cnt     <= 5'd0;
          err_timeout <= 1'b0;
          err_bad_key <= 1'b0;
        end
        S_START: to_cnt <= 8'd0;
        S_WAIT: begin
          to_cnt <= to_cnt + 8'd1;
          // An abandoned letter leaves the rotors stepped; only the error is recorded.
          if (cipher_done)            out_data    <= cipher_out;
          else if (to_cnt == TO_LAST) err_timeout <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            char_count <= char_count + CNT_W'(1);
            grp_cnt    <= (grp_cnt == GRP_LAST) ? 5'd0 : grp_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_key_sequencer.sv
// Bench for enigma_key_sequencer: behavioural substitution datapath plus a
// scoreboard of expected ciphertext letters and group-end flags.
module tb_enigma_key_sequencer;
  localparam int GROUP_LEN = 5;
  localparam int TIMEOUT   = 64;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_load_req = 1'b0;
  logic             key_valid = 1'b0;
  logic [4:0]       key_data = 5'd0;
  logic             key_ready;
  logic             step_pulse;
  logic             load_pulse;
  logic             cipher_start;
  logic [4:0]       cipher_in;
  logic             cipher_done = 1'b0;
  logic [4:0]       cipher_out = 5'd0;
  logic             out_valid;
  logic [4:0]       out_data;
  logic             out_group_end;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] char_count;
  logic             busy;
  logic             err_timeout;
  logic             err_bad_key;

  int         checks = 0;
  int         failures = 0;
  logic [5:0] exp_q[$];
  int         exp_grp = 0;
  int         dp_lat = 1;
  bit         dp_hang = 1'b0;
  int         dp_pend = 0;
  int         n_step = 0;
  int         n_start = 0;

  always #5 clk = ~clk;

  enigma_key_sequencer #(
    .GROUP_LEN(GROUP_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load_req(cfg_load_req),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .step_pulse(step_pulse), .load_pulse(load_pulse),
    .cipher_start(cipher_start), .cipher_in(cipher_in),
    .cipher_done(cipher_done), .cipher_out(cipher_out),
    .out_valid(out_valid), .out_data(out_data), .out_group_end(out_group_end),
    .out_ready(out_ready), .char_count(char_count), .busy(busy),
    .err_timeout(err_timeout), .err_bad_key(err_bad_key)
  );

  function automatic logic [4:0] xf(input logic [4:0] k);
    return 5'((int'(k) * 7 + 3) % 26);
  endfunction

  // Stand-in datapath: cipher_done arrives dp_lat cycles after cipher_start.
  always @(negedge clk) begin
    cipher_done = 1'b0;
    if (!rst_n) begin
      dp_pend = 0;
    end else begin
      if (dp_pend > 0) begin
        dp_pend = dp_pend - 1;
        if (dp_pend == 0) begin
          cipher_done = 1'b1;
          cipher_out  = xf(cipher_in);
        end
      end
      if (cipher_start && !dp_hang) dp_pend = dp_lat;
      if (step_pulse)   n_step  = n_step + 1;
      if (cipher_start) n_start = n_start + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] k);
    exp_q.push_back({(exp_grp == GROUP_LEN - 1), xf(k)});
    exp_grp = (exp_grp + 1) % GROUP_LEN;
  endtask

  task automatic send_key(input logic [4:0] k, input bit expect_out);
    int n = 0;
    key_valid = 1'b1;
    key_data  = k;
    while (!key_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!key_ready) begin
      failures++;
      $display("FAIL send_key: key_ready=%0b required 1 within 200 cycles", key_ready);
    end else if (expect_out && k <= 5'd25) begin
      push_exp(k);
    end
    tick();
    key_valid = 1'b0;
  endtask

  task automatic collect(input string nm);
    int n = 0;
    logic [5:0] e;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s: out_valid=%0b required 1 within 300 cycles", nm, out_valid);
    end else if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: out_data=%0d appeared, required no output", nm, out_data);
    end else begin
      e = exp_q.pop_front();
      if ({out_group_end, out_data} !== e) begin
        failures++;
        $display("FAIL %s: group_end/data=%0b/%0d required %0b/%0d",
                 nm, out_group_end, out_data, e[5], e[4:0]);
      end
    end
    tick();
  endtask

  task automatic do_load();
    cfg_load_req = 1'b1;
    tick();
    cfg_load_req = 1'b0;
    tick();
    exp_grp = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: key_ready/busy=%0b/%0b required 1/0", key_ready, busy);
    end
    checks++;
    if ({step_pulse, load_pulse, cipher_start, out_valid, out_group_end,
         err_timeout, err_bad_key} !== 7'd0) begin
      failures++;
      $display("FAIL reset_flags: step/load/start/valid/gend/eto/ebk=%0b%0b%0b%0b%0b%0b%0b required 0000000",
               step_pulse, load_pulse, cipher_start, out_valid, out_group_end, err_timeout, err_bad_key);
    end
    checks++;
    if (char_count !== '0 || out_data !== 5'd0 || cipher_in !== 5'd0) begin
      failures++;
      $display("FAIL reset_data: count/out_data/cipher_in=%0d/%0d/%0d required 0/0/0",
               char_count, out_data, cipher_in);
    end
  endtask

  task automatic test_load();
    int s0 = n_step;
    key_valid    = 1'b1;
    key_data     = 5'd3;
    cfg_load_req = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_priority: key_ready=%0b required 0", key_ready);
    end
    tick();
    cfg_load_req = 1'b0;
    key_valid    = 1'b0;
    checks++;
    if (load_pulse !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_pulse: load_pulse/busy=%0b/%0b required 1/1", load_pulse, busy);
    end
    tick();
    checks++;
    if (load_pulse !== 1'b0 || char_count !== '0 || n_step != s0) begin
      failures++;
      $display("FAIL load_after: load_pulse/count/steps=%0b/%0d/%0d required 0/0/%0d",
               load_pulse, char_count, n_step, s0);
    end
    exp_grp = 0;
  endtask

  task automatic test_single();
    logic [5:0] e;
    out_ready = 1'b1;
    dp_lat    = 1;
    key_valid = 1'b1;
    key_data  = 5'd0;
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready: key_ready=%0b required 1", key_ready);
    end
    push_exp(5'd0);
    tick();
    key_valid = 1'b0;
    checks++;
    if (step_pulse !== 1'b1 || cipher_start !== 1'b0) begin
      failures++;
      $display("FAIL single_step: step/start=%0b/%0b required 1/0", step_pulse, cipher_start);
    end
    tick();
    checks++;
    if (cipher_start !== 1'b1 || step_pulse !== 1'b0 || cipher_in !== 5'd0) begin
      failures++;
      $display("FAIL single_start: start/step/cipher_in=%0b/%0b/%0d required 1/0/0",
               cipher_start, step_pulse, cipher_in);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_wait: out_valid/busy=%0b/%0b required 0/1", out_valid, busy);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_group_end, out_data} !== e) begin
      failures++;
      $display("FAIL single_out: valid/gend/data=%0b/%0b/%0d required 1/%0b/%0d",
               out_valid, out_group_end, out_data, e[5], e[4:0]);
    end
    tick();
    checks++;
    if (char_count !== CNT_W'(1) || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_count: count/busy=%0d/%0b required 1/0", char_count, busy);
    end
  endtask

  task automatic test_stream();
    int s0;
    do_load();
    s0 = n_step;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dp_lat = 1 + (i % 3);
      send_key(5'((i * 3) % 26), 1'b1);
      collect("stream");
    end
    checks++;
    if (char_count !== CNT_W'(10) || n_step != s0 + 10) begin
      failures++;
      $display("FAIL stream_totals: count/steps=%0d/%0d required 10/%0d",
               char_count, n_step, s0 + 10);
    end
  endtask

  task automatic test_backpressure();
    int s0 = n_step;
    int n = 0;
    out_ready = 1'b0;
    dp_lat    = 2;
    send_key(5'd12, 1'b1);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    key_valid = 1'b1;
    key_data  = 5'd7;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0][4:0] ||
          out_group_end !== exp_q[0][5] || key_ready !== 1'b0 || n_step != s0 + 1) begin
        failures++;
        $display("FAIL hold_%0d: valid/data/gend/key_ready/steps=%0b/%0d/%0b/%0b/%0d required 1/%0d/%0b/0/%0d",
                 i, out_valid, out_data, out_group_end, key_ready, n_step,
                 exp_q[0][4:0], exp_q[0][5], s0 + 1);
      end
      tick();
    end
    key_valid = 1'b0;
    out_ready = 1'b1;
    collect("backpressure");
  endtask

  task automatic test_timeout();
    bit saw_out = 1'b0;
    dp_hang = 1'b1;
    send_key(5'd4, 1'b0);
    repeat (65) begin
      tick();
      if (out_valid) saw_out = 1'b1;
    end
    checks++;
    if (busy !== 1'b1 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_last_wait: busy/err_timeout=%0b/%0b required 1/0", busy, err_timeout);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || saw_out) begin
      failures++;
      $display("FAIL timeout_abandon: err_timeout/busy/saw_out=%0b/%0b/%0b required 1/0/0",
               err_timeout, busy, saw_out);
    end
    dp_hang = 1'b0;
    do_load();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: err_timeout=%0b required 0", err_timeout);
    end
  endtask

  task automatic test_bad_key();
    int s0 = n_step;
    int c0 = n_start;
    send_key(5'd26, 1'b0);
    repeat (3) tick();
    checks++;
    if (err_bad_key !== 1'b1 || n_step != s0 || n_start != c0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_key: err_bad_key/steps/starts/busy=%0b/%0d/%0d/%0b required 1/%0d/%0d/0",
               err_bad_key, n_step, n_start, busy, s0, c0);
    end
  endtask

  task automatic test_reset_wait();
    dp_hang = 1'b1;
    send_key(5'd9, 1'b0);
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_pre: busy/out_valid=%0b/%0b required 1/0", busy, out_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (key_ready !== 1'b1 || {step_pulse, load_pulse, cipher_start, out_valid,
        out_group_end, busy, err_timeout, err_bad_key} !== 8'd0 ||
        out_data !== 5'd0 || cipher_in !== 5'd0 || char_count !== '0) begin
      failures++;
      $display("FAIL rst_wait_post: key_ready=%0b flags=%0b%0b%0b%0b%0b%0b%0b%0b data/in/count=%0d/%0d/%0d required 1 00000000 0/0/0",
               key_ready, step_pulse, load_pulse, cipher_start, out_valid, out_group_end,
               busy, err_timeout, err_bad_key, out_data, cipher_in, char_count);
    end
    dp_hang = 1'b0;
    exp_grp = 0;
  endtask

  task automatic test_after_reset();
    out_ready = 1'b1;
    dp_lat    = 1;
    send_key(5'd25, 1'b1);
    collect("after_reset");
    checks++;
    if (char_count !== CNT_W'(1) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset_count: count/pending=%0d/%0d required 1/0", char_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_single();
    test_stream();
    test_backpressure();
    test_timeout();
    test_bad_key();
    test_reset_wait();
    test_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
